// File: rtl/dtree_top.sv
`default_nettype none
// ============================================================================
// dtree_top : registered depth-3 decision-tree classifier, 5-bit class label.
// Option macro DTREE_INPUT_REG_EN adds an input register stage (latency 2).
// Rev 1.0
// ============================================================================
module dtree_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] X13,
    input  logic [7:0] X27,
    input  logic [7:0] X235,
    input  logic [7:0] X264,
    input  logic [7:0] X278,
    output logic       out_valid,
    output logic [4:0] out
);

    localparam logic [7:0] C_T_N0 = 8'd90;
    localparam logic [7:0] C_T_N1 = 8'd40;
    localparam logic [7:0] C_T_N2 = 8'd128;
    localparam logic [7:0] C_T_N3 = 8'd60;
    localparam logic [7:0] C_T_N4 = 8'd100;
    localparam logic [7:0] C_T_N5 = 8'd200;
    localparam logic [7:0] C_T_N6 = 8'd30;

    localparam logic [4:0] C_L_N3_T = 5'd1;
    localparam logic [4:0] C_L_N3_F = 5'd10;
    localparam logic [4:0] C_L_N4_T = 5'd2;
    localparam logic [4:0] C_L_N4_F = 5'd6;
    localparam logic [4:0] C_L_N5_T = 5'd5;
    localparam logic [4:0] C_L_N5_F = 5'd1;
    localparam logic [4:0] C_L_N6_T = 5'd16;
    localparam logic [4:0] C_L_N6_F = 5'd9;

    logic       w_valid;
    logic [7:0] w_x13;
    logic [7:0] w_x27;
    logic [7:0] w_x235;
    logic [7:0] w_x264;
    logic [7:0] w_x278;

`ifdef DTREE_INPUT_REG_EN
    logic       r_valid_in;
    logic [7:0] r_x13;
    logic [7:0] r_x27;
    logic [7:0] r_x235;
    logic [7:0] r_x264;
    logic [7:0] r_x278;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_in <= 1'b0;
            r_x13      <= 8'd0;
            r_x27      <= 8'd0;
            r_x235     <= 8'd0;
            r_x264     <= 8'd0;
            r_x278     <= 8'd0;
        end else begin
            r_valid_in <= in_valid;
            r_x13      <= X13;
            r_x27      <= X27;
            r_x235     <= X235;
            r_x264     <= X264;
            r_x278     <= X278;
        end
    end

    assign w_valid = r_valid_in;
    assign w_x13   = r_x13;
    assign w_x27   = r_x27;
    assign w_x235  = r_x235;
    assign w_x264  = r_x264;
    assign w_x278  = r_x278;
`else
    assign w_valid = in_valid;
    assign w_x13   = X13;
    assign w_x27   = X27;
    assign w_x235  = X235;
    assign w_x264  = X264;
    assign w_x278  = X278;
`endif

    // All seven node decisions are computed in parallel; the mux picks the leaf.
    logic       w_c0, w_c1, w_c2, w_c3, w_c4, w_c5, w_c6;
    logic [4:0] w_left;
    logic [4:0] w_right;
    logic [4:0] w_label;

    assign w_c0 = (w_x13  <= C_T_N0);
    assign w_c1 = (w_x27  <= C_T_N1);
    assign w_c2 = (w_x264 <= C_T_N2);
    assign w_c3 = (w_x235 <= C_T_N3);
    assign w_c4 = (w_x278 <= C_T_N4);
    assign w_c5 = (w_x235 <= C_T_N5);
    assign w_c6 = (w_x278 <= C_T_N6);

    assign w_left  = w_c1 ? (w_c3 ? C_L_N3_T : C_L_N3_F)
                          : (w_c4 ? C_L_N4_T : C_L_N4_F);
    assign w_right = w_c2 ? (w_c5 ? C_L_N5_T : C_L_N5_F)
                          : (w_c6 ? C_L_N6_T : C_L_N6_F);
    assign w_label = w_c0 ? w_left : w_right;

    // Label only loads on a valid slot so out holds across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= 5'd0;
        end else begin
            out_valid <= w_valid;
            if (w_valid) begin
                out <= w_label;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtree_top.sv
`default_nettype none
// ============================================================================
// tb_dtree_top : directed self-checking bench for dtree_top.
// Rev 1.0
// ============================================================================
module tb_dtree_top;

`ifdef DTREE_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] X13 = 8'd0;
    logic [7:0] X27 = 8'd0;
    logic [7:0] X235 = 8'd0;
    logic [7:0] X264 = 8'd0;
    logic [7:0] X278 = 8'd0;
    logic       out_valid;
    logic [4:0] out;

    int checks = 0;
    int failures = 0;

    dtree_top dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .X13       (X13),
        .X27       (X27),
        .X235      (X235),
        .X264      (X264),
        .X278      (X278),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
        in_valid = v;
        X13 = a; X27 = b; X235 = c; X264 = d; X278 = e;
    endtask

    // Present one sample for one cycle, then idle until its result slot.
    task automatic send_and_wait(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d,
                                 input logic [7:0] e);
        drive(1'b1, a, b, c, d, e);
        @(posedge clk); #1;
        drive(1'b0, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h0F);
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            @(posedge clk); #3;
            checks++;
            if (out !== 5'd0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: out=%0d out_valid=%b, required out=0 out_valid=0", out, out_valid);
            end
        end
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_left_path;
        send_and_wait(8'd50, 8'd20, 8'd61, 8'd0, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd10) begin
            failures++;
            $display("FAIL left_n3_false: out=%0d out_valid=%b, required out=10 out_valid=1", out, out_valid);
        end
        send_and_wait(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd1) begin
            failures++;
            $display("FAIL left_n3_true: out=%0d out_valid=%b, required out=1 out_valid=1", out, out_valid);
        end
    endtask

    task automatic test_boundary;
        send_and_wait(8'd90, 8'd41, 8'd0, 8'd0, 8'd100);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd2) begin
            failures++;
            $display("FAIL boundary_x278_100: out=%0d out_valid=%b, required out=2 out_valid=1", out, out_valid);
        end
        send_and_wait(8'd90, 8'd41, 8'd0, 8'd0, 8'd101);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd6) begin
            failures++;
            $display("FAIL boundary_x278_101: out=%0d out_valid=%b, required out=6 out_valid=1", out, out_valid);
        end
        send_and_wait(8'd90, 8'd40, 8'd60, 8'd0, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd1) begin
            failures++;
            $display("FAIL boundary_x27_x235: out=%0d out_valid=%b, required out=1 out_valid=1", out, out_valid);
        end
    endtask

    task automatic test_right_path;
        send_and_wait(8'd91, 8'd0, 8'd0, 8'd129, 8'd31);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd9) begin
            failures++;
            $display("FAIL right_n6_false: out=%0d out_valid=%b, required out=9 out_valid=1", out, out_valid);
        end
        send_and_wait(8'd255, 8'd0, 8'd201, 8'd128, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd1) begin
            failures++;
            $display("FAIL right_n5_false: out=%0d out_valid=%b, required out=1 out_valid=1", out, out_valid);
        end
        send_and_wait(8'd255, 8'd0, 8'd200, 8'd128, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd5) begin
            failures++;
            $display("FAIL right_n5_true: out=%0d out_valid=%b, required out=5 out_valid=1", out, out_valid);
        end
        send_and_wait(8'd200, 8'd0, 8'd0, 8'd200, 8'd30);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd16) begin
            failures++;
            $display("FAIL right_n6_true: out=%0d out_valid=%b, required out=16 out_valid=1", out, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sx13 [4];
        logic [7:0] sx27 [4];
        logic [7:0] sx235[4];
        logic [7:0] sx264[4];
        logic [7:0] sx278[4];
        logic [4:0] exp  [4];
        int idx;
        sx13 = '{8'd200, 8'd10, 8'd91, 8'd50};
        sx27 = '{8'd0,   8'd41, 8'd0,  8'd20};
        sx235= '{8'd0,   8'd0,  8'd150,8'd61};
        sx264= '{8'd255, 8'd0,  8'd0,  8'd0};
        sx278= '{8'd0,   8'd50, 8'd0,  8'd0};
        exp  = '{5'd16,  5'd2,  5'd5,  5'd10};
        for (int t = 0; t < 4 + LAT; t++) begin
            if (t < 4) drive(1'b1, sx13[t], sx27[t], sx235[t], sx264[t], sx278[t]);
            else       drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            @(posedge clk); #1;
            idx = t - (LAT - 1);
            if (idx >= 0 && idx < 4) begin
                checks++;
                if (out_valid !== 1'b1 || out !== exp[idx]) begin
                    failures++;
                    $display("FAIL stream_%0d: out=%0d out_valid=%b, required out=%0d out_valid=1", idx, out, out_valid, exp[idx]);
                end
            end else if (idx == 4) begin
                checks++;
                if (out_valid !== 1'b0 || out !== 5'd10) begin
                    failures++;
                    $display("FAIL stream_idle_hold: out=%0d out_valid=%b, required out=10 out_valid=0", out, out_valid);
                end
            end
        end
        // Invalid samples must never raise out_valid, and out keeps its value.
        drive(1'b0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd30);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || out !== 5'd10) begin
            failures++;
            $display("FAIL invalid_ignored: out=%0d out_valid=%b, required out=10 out_valid=0", out, out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 8'd91, 8'd0, 8'd0, 8'd129, 8'd31);
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 5'd0) begin
            failures++;
            $display("FAIL reset_async: out=%0d out_valid=%b, required out=0 out_valid=0", out, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_discard_%0d: out_valid=%b, required 0", i, out_valid);
            end
        end
        send_and_wait(8'd50, 8'd20, 8'd61, 8'd0, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd10) begin
            failures++;
            $display("FAIL reset_first_after: out=%0d out_valid=%b, required out=10 out_valid=1", out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_left_path();
        test_boundary();
        test_right_path();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtree_top.md
# dtree_top

Registered decision-tree classifier for the arrhythmia feature set. Each accepted sample carries five unsigned 8-bit features (X13, X27, X235, X264, X278). The block walks a fixed depth-3 binary tree of threshold comparisons and returns a 5-bit class label. It sits between the feature-extraction front end and the result collector, accepts one sample per clock, and runs as a fixed-latency pipeline.

## Interface
Parameters: none. Thresholds and leaf labels are fixed constants, listed under Operation.

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  sample on X* is valid this cycle
- X13  input  8  feature 13, unsigned
- X27  input  8  feature 27, unsigned
- X235  input  8  feature 235, unsigned
- X264  input  8  feature 264, unsigned
- X278  input  8  feature 278, unsigned
- out_valid  output  1  out holds the class of an accepted sample
- out  output  5  class label, 1..16

## Operation
All comparisons are unsigned and use <= ("true" selects the left branch). The tree nodes are:

- n0: X13 <= 90 ? n1 : n2
- n1: X27 <= 40 ? n3 : n4
- n2: X264 <= 128 ? n5 : n6
- n3: X235 <= 60 ? class 1 : class 10
- n4: X278 <= 100 ? class 2 : class 6
- n5: X235 <= 200 ? class 5 : class 1
- n6: X278 <= 30 ? class 16 : class 9

Implementation rules:
- Evaluate all seven comparators in parallel. A mux tree selects the leaf; there is no sequential traversal.
- There is no back-pressure. Every cycle with in_valid=1 produces exactly one result, in order.
- When in_valid=0, the pipeline still shifts: out_valid goes to 0 at the matching output slot, and out holds its last value.
- Feature values captured while in_valid=0 are don't-care and must never produce out_valid=1.

## Timing
- Reset values: out=5'd0, out_valid=0, and all pipeline registers cleared. Reset acts immediately; it does not wait for a clock edge.
- Latency with DTREE_INPUT_REG_EN defined: 2 cycles. The sample is presented at edge k, out and out_valid are updated at edge k+2.
- Latency without DTREE_INPUT_REG_EN: 1 cycle. Comparators read the ports directly, and the result is registered at edge k+1.
- Throughput: 1 sample per cycle. Back-to-back valid samples produce back-to-back valid outputs.
- Reset asserted mid-stream discards every in-flight sample. The first valid result after rst deasserts belongs to the first sample accepted after deassertion.
- out changes only on clock edges or reset. It must be glitch-free as seen by registered consumers.

## Configuration
- Macro: DTREE_INPUT_REG_EN.
- Defined: in_valid and the five features are captured into an input register stage ahead of the comparators, giving a 2-cycle latency. This is intended for printed or slow technologies with long input wires.
- Undefined: there is no input register stage and latency is 1 cycle. Classification results are identical in both builds.

## Test plan
- Reset: assert rst with random inputs and in_valid=1 -> out=0 and out_valid=0 while rst is high, including between clock edges.
- Left-path leaf: X13=50, X27=20, X235=61, others 0 -> out=10, with out_valid=1 after the configured latency.
- Boundary on the `<=` comparisons: X13=90, X27=41, X278=100 -> out=2. The same sample with X278=101 -> out=6.
- Right-path leaves:
  - X13=91, X264=129, X278=31 -> out=9.
  - X13=255, X264=128, X235=201 -> out=1.
  - X13=255, X264=128, X235=200 -> out=5.
- Streaming: four consecutive valid samples, then in_valid=0 -> four consecutive out_valid=1 cycles carrying the labels in order, followed by out_valid=0 with out held.
- Reset mid-stream: assert rst one cycle after a valid sample -> no out_valid for that sample; the next sample after deassertion is classified correctly.
